// File: rtl/regfile_pkg.sv
// Shared widths and write-request bundle for the register file write path.
// Address 0 is the hardwired-zero register.
package regfile_pkg;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;
endpackage

// File: rtl/decoder5to32.sv
// One-hot address decoder with enable; all-zero output when disabled.
module decoder5to32
   import regfile_pkg::*;
#(
   parameter int N = ADDR_W
) (
   input  logic            en_i,
   input  logic [N-1:0]    addr_i,
   output logic [2**N-1:0] onehot_o
);
   always_comb begin
      onehot_o = '0;
      if (en_i) onehot_o[addr_i] = 1'b1;
   end
endmodule

// File: rtl/regfile_write_queue.sv
// Buffered register-file write port: FIFO of {addr, data}, one drain per cycle.
// Define REGWRITE_COALESCE_EN to merge a write into the youngest same-address entry.
module regfile_write_queue
   import regfile_pkg::wr_req_t;
   import regfile_pkg::REG_ZERO;
#(
   parameter  int DEPTH  = 4,
   parameter  int ADDR_W = regfile_pkg::ADDR_W,
   parameter  int DATA_W = regfile_pkg::DATA_W,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = PTR_W + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic                 hold,
   output logic [2**ADDR_W-1:0] wrenable,
   output logic [DATA_W-1:0]    wrdata,
   output logic [CNT_W-1:0]     count
);
   logic [PTR_W-1:0]     head_q, head_d;
   logic [PTR_W-1:0]     tail_q, tail_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [2**ADDR_W-1:0] wren_q, wren_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic [2**ADDR_W-1:0] dec;
   wr_req_t              mem_q [DEPTH];

   logic accept, nonzero, pop, push, coal;

   assign wr_ready = (count_q != CNT_W'(DEPTH));
   assign accept   = wr_valid && wr_ready;
   assign nonzero  = (wr_addr != REG_ZERO);
   assign pop      = (count_q != '0) && !hold;

`ifdef REGWRITE_COALESCE_EN
   logic [PTR_W-1:0] young;
   assign young = tail_q - PTR_W'(1);
   // A lone entry leaving this cycle cannot absorb the write.
   assign coal  = accept && nonzero && (count_q != '0)
                  && (mem_q[young].addr == wr_addr)
                  && !((count_q == CNT_W'(1)) && pop);
`else
   assign coal  = 1'b0;
`endif

   assign push = accept && nonzero && !coal;

   decoder5to32 #(
      .N(ADDR_W)
   ) u_dec (
      .en_i    (pop),
      .addr_i  (mem_q[head_q].addr),
      .onehot_o(dec)
   );

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      wren_d  = dec;
      wdata_d = wdata_q;
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop) begin
         head_d  = head_q + PTR_W'(1);
         wdata_d = mem_q[head_q].data;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         wren_q  <= '0;
         wdata_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         wren_q  <= wren_d;
         wdata_q <= wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[tail_q] <= '{addr: wr_addr, data: wr_data};
`ifdef REGWRITE_COALESCE_EN
      if (coal) mem_q[young].data <= wr_data;
`endif
   end

   assign wrenable = wren_q;
   assign wrdata   = wdata_q;
   assign count    = count_q;
endmodule

// File: tb/tb_regfile_write_queue.sv
// Scoreboard bench for regfile_write_queue (DEPTH 4, 32x32).
module tb_regfile_write_queue;
   logic        clk = 1'b0;
   logic        reset;
   logic        wr_valid;
   logic        wr_ready;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        hold;
   logic [31:0] wrenable;
   logic [31:0] wrdata;
   logic [2:0]  count;

   int total = 0;
   int bad = 0;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   regfile_write_queue dut (
      .clk     (clk),
      .reset   (reset),
      .wr_valid(wr_valid),
      .wr_ready(wr_ready),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .hold    (hold),
      .wrenable(wrenable),
      .wrdata  (wrdata),
      .count   (count)
   );

   always @(negedge clk) begin
      if (!reset && wrenable !== 32'h0) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL spurious_write wrenable=%h wrdata=%h required no write",
                     wrenable, wrdata);
         end else begin
            mon_e = sb.pop_front();
            if (wrenable !== (32'h1 << mon_e.a) || wrdata !== mon_e.d) begin
               bad++;
               $display("FAIL sb_write wrenable=%h wrdata=%h required %h %h",
                        wrenable, wrdata, 32'h1 << mon_e.a, mon_e.d);
            end
         end
      end
   end

   task automatic exp_push(input logic [4:0] a, input logic [31:0] d);
      if (a != 5'd0) sb.push_back('{a: a, d: d});
   endtask

   task automatic drive(input logic [4:0] a, input logic [31:0] d);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      for (int i = 0; i < 40; i++) begin
         if (sb.size() == 0 && count == 3'd0) break;
         @(negedge clk);
      end
      total++;
      if (sb.size() != 0 || count !== 3'd0) begin
         bad++;
         $display("FAIL %s_drain left=%0d count=%0d required 0 0",
                  nm, sb.size(), count);
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      total++;
      if (count !== 3'd0 || wr_ready !== 1'b1 || wrenable !== 32'h0
          || wrdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_vals cnt=%0d rdy=%b en=%h d=%h required 0 1 0 0",
                  count, wr_ready, wrenable, wrdata);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single;
      exp_push(5'd5, 32'hDEADBEEF);
      drive(5'd5, 32'hDEADBEEF);
      total++;
      if (count !== 3'd1 || wrenable !== 32'h0) begin
         bad++;
         $display("FAIL single_lat cnt=%0d en=%h required 1 0", count, wrenable);
      end
      @(negedge clk);
      total++;
      if (wrenable !== 32'h20 || wrdata !== 32'hDEADBEEF || count !== 3'd0) begin
         bad++;
         $display("FAIL single_out en=%h d=%h cnt=%0d required 20 deadbeef 0",
                  wrenable, wrdata, count);
      end
      @(negedge clk);
      total++;
      if (wrenable !== 32'h0 || wrdata !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL single_idle en=%h d=%h required 0 deadbeef",
                  wrenable, wrdata);
      end
   endtask

   task automatic test_zero;
      total++;
      if (wr_ready !== 1'b1) begin
         bad++;
         $display("FAIL zero_ready rdy=%b required 1", wr_ready);
      end
      drive(5'd0, 32'h12345678);
      for (int i = 0; i < 2; i++) begin
         total++;
         if (count !== 3'd0 || wrenable !== 32'h0) begin
            bad++;
            $display("FAIL zero_drop cnt=%0d en=%h required 0 0", count, wrenable);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_fill;
      hold = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         exp_push(5'(i), 32'hA000_0000 + 32'(i));
         drive(5'(i), 32'hA000_0000 + 32'(i));
      end
      total++;
      if (count !== 3'd4 || wr_ready !== 1'b0) begin
         bad++;
         $display("FAIL fill_full cnt=%0d rdy=%b required 4 0", count, wr_ready);
      end
      drive(5'd6, 32'h6666);
      total++;
      if (count !== 3'd4 || wrenable !== 32'h0) begin
         bad++;
         $display("FAIL fill_reject cnt=%0d en=%h required 4 0", count, wrenable);
      end
      hold = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         total++;
         if (wrenable !== (32'h1 << i) || wr_ready !== 1'b1
             || count !== 3'(4 - i)) begin
            bad++;
            $display("FAIL fill_drain%0d en=%h rdy=%b cnt=%0d required %h 1 %0d",
                     i, wrenable, wr_ready, count, 32'h1 << i, 4 - i);
         end
      end
      wait_drain("fill");
   endtask

   task automatic test_pushpop;
      hold = 1'b1;
      exp_push(5'd10, 32'h10);
      drive(5'd10, 32'h10);
      exp_push(5'd11, 32'h11);
      drive(5'd11, 32'h11);
      hold = 1'b0;
      exp_push(5'd7, 32'h77);
      drive(5'd7, 32'h77);
      total++;
      if (count !== 3'd2 || wrenable !== (32'h1 << 10)) begin
         bad++;
         $display("FAIL pushpop cnt=%0d en=%h required 2 %h",
                  count, wrenable, 32'h1 << 10);
      end
      wait_drain("pushpop");
   endtask

   task automatic test_coalesce;
      hold = 1'b1;
      drive(5'd9, 32'h1);
      drive(5'd9, 32'h2);
`ifdef REGWRITE_COALESCE_EN
      exp_push(5'd9, 32'h2);
      total++;
      if (count !== 3'd1) begin
         bad++;
         $display("FAIL coalesce_cnt cnt=%0d required 1", count);
      end
`else
      exp_push(5'd9, 32'h1);
      exp_push(5'd9, 32'h2);
      total++;
      if (count !== 3'd2) begin
         bad++;
         $display("FAIL coalesce_cnt cnt=%0d required 2", count);
      end
`endif
      hold = 1'b0;
      wait_drain("coalesce");
   endtask

   task automatic test_back_to_back;
      hold = 1'b0;
      wr_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wr_addr = 5'(12 + i);
         wr_data = $urandom;
         exp_push(wr_addr, wr_data);
         @(negedge clk);
         total++;
         if (count > 3'd1 || wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_rate%0d cnt=%0d rdy=%b required <=1 1",
                     i, count, wr_ready);
         end
      end
      wr_valid = 1'b0;
      wait_drain("b2b");
   endtask

   task automatic test_reset_mid;
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_push(5'(3 + i), 32'hC0 + 32'(i));
         drive(5'(3 + i), 32'hC0 + 32'(i));
      end
      total++;
      if (count !== 3'd3) begin
         bad++;
         $display("FAIL rmid_fill cnt=%0d required 3", count);
      end
      #2;
      reset = 1'b1;
      #1;
      sb.delete();
      total++;
      if (count !== 3'd0 || wrenable !== 32'h0 || wrdata !== 32'h0
          || wr_ready !== 1'b1) begin
         bad++;
         $display("FAIL rmid_async cnt=%0d en=%h d=%h rdy=%b required 0 0 0 1",
                  count, wrenable, wrdata, wr_ready);
      end
      @(negedge clk);
      reset = 1'b0;
      hold = 1'b0;
      for (int i = 0; i < 5; i++) @(negedge clk);
      total++;
      if (count !== 3'd0 || wrenable !== 32'h0) begin
         bad++;
         $display("FAIL rmid_after cnt=%0d en=%h required 0 0", count, wrenable);
      end
   endtask

   initial begin
      reset    = 1'b1;
      wr_valid = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      hold     = 1'b0;
      test_reset();
      test_single();
      test_zero();
      test_fill();
      test_pushpop();
      test_coalesce();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/regfile_write_queue.md
# regfile_write_queue

Buffered write port for the 32×32 register file. Accepts write requests (address, data) over a valid/ready handshake and holds them in a small FIFO. It drains one entry per cycle into the register array as a registered one-hot `wrenable` vector plus a shared data bus. It is the write-side counterpart of the 32:1 read multiplexers and enforces the hardwired-zero register by dropping writes to address 0.

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `ADDR_W`, 5: register address width; the array has 2^ADDR_W registers.
- `DATA_W`, 32: register data width.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `wr_valid`  in  1  write request present.
- `wr_ready`  out  1  queue can accept; equals `count != DEPTH`.
- `wr_addr`  in  ADDR_W  destination register.
- `wr_data`  in  DATA_W  write value.
- `hold`  in  1  stalls draining while high; register array busy.
- `wrenable`  out  2^ADDR_W  registered one-hot write enables to the array; all-zero when idle.
- `wrdata`  out  DATA_W  registered data accompanying `wrenable`.
- `count`  out  clog2(DEPTH)+1  current occupancy.

## Operation

- Accept: `wr_valid && wr_ready` at a posedge.
- Address 0: accepted (handshake completes) but not stored. `count` does not change. `wrenable` never asserts bit 0.
- Push: stores {addr, data} at the tail. The tail pointer wraps modulo DEPTH.
- Pop: when `count != 0 && !hold` at a posedge, the head is removed and the outputs register `wrenable <= decode(head.addr)` and `wrdata <= head.data`. Otherwise the outputs register `wrenable <= 0` and `wrdata` holds its value.
- Push and pop in the same cycle: both occur and `count` is unchanged.
- Full queue: `wr_ready` is low. There is no pass-through, even if a pop occurs in the same cycle.
- Entries drain strictly in FIFO order. Duplicate addresses are written in arrival order unless coalesced (see Configuration).
- There is no internal state machine beyond the pointers and counter. States are effectively EMPTY (count 0), PARTIAL, and FULL (count DEPTH), with transitions by push/pop as above.

## Timing

- Reset values: `wrenable` = 0, `wrdata` = 0, `count` = 0, head = tail = 0, so `wr_ready` = 1. No accept occurs while `reset` is high.
- Latency: a write accepted at edge N into an empty queue with `hold` low produces `wrenable` one-hot at edge N+1, valid for exactly one cycle.
- Throughput: one write per cycle sustained with `hold` low.
- `hold` asserted: `wrenable` is 0 from the next edge. Queued entries are retained and accepts continue until full.
- Reset mid-operation: queued entries are discarded and no write enable is issued for them. Outputs go to reset values asynchronously.
- `wr_ready` is combinational from `count` only. It never depends on `wr_valid`.

## Configuration

- `REGWRITE_COALESCE_EN` defined: an accepted write whose address equals the youngest queued entry's address overwrites that entry's data in place, and `count` does not change. Exception: the youngest entry is also the head and is being popped in the same cycle; then a normal push occurs. `wr_ready` remains `count != DEPTH`, so no accept is taken when full even if it would coalesce.
- Not defined: every nonzero-address accept pushes a new entry.

## Structure

- Shared package `regfile_pkg` contains:
  - `ADDR_W` and `DATA_W` constants.
  - `REG_ZERO` constant (address 0).
  - `wr_req_t` struct {addr, data}.
- Sub-module `decoder5to32`: a combinational one-hot decoder with an enable input. It is instantiated once on the head address, gated by the pop condition.
- The FIFO storage is a `wr_req_t` array indexed by head/tail pointers.

## Test plan

- Single write: after reset, push addr 5, data 0xDEADBEEF → next cycle `wrenable` = 0x00000020 and `wrdata` = 0xDEADBEEF for one cycle; `count` returns to 0.
- Zero drop: push addr 0, data 0x12345678 → handshake completes, `count` stays 0, `wrenable` stays 0.
- Fill and stall: with `hold` = 1, push addresses 1, 2, 3, 4 → `count` = 4 and `wr_ready` = 0. Release `hold` → `wrenable` = 0x2, 0x4, 0x8, 0x10 on consecutive cycles, and `wr_ready` rises after the first pop.
- Simultaneous push/pop: with `count` = 2 and `hold` = 0, push addr 7 → `count` stays 2 and order is preserved (addr 7 drains last).
- Coalesce: with `hold` = 1, push addr 9 = 0x1 then addr 9 = 0x2.
  - With `REGWRITE_COALESCE_EN`: `count` = 1 and the drain gives a single write of 0x2.
  - Without it: `count` = 2 and the drain gives writes of 0x1 then 0x2.
- Reset mid-operation: with 3 entries queued, assert `reset` mid-cycle → outputs clear immediately, `count` = 0, and no `wrenable` pulse occurs after deassertion.
